// File: rtl/audio_rx_pkg.sv
// Shared constants and types for the serial audio receive path.
//   AUDIO_LRC_LEFT : ws_lrc level that marks the left channel (same as audio_tx)
//   rx_state_e     : frame-tracking FSM states
package audio_rx_pkg;

    // LR clock level for the left channel; right channel is the inverse.
    localparam logic AUDIO_LRC_LEFT = 1'b1;

    // Stages in front of the edge detector (metastability flop + settled flop).
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/audio_rx_sync_edge_det.sv
// 2-FF synchroniser with registered rise/fall detection for one asynchronous
// 1-bit input.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   din  in  asynchronous input
//   rise out 1-clk pulse, synchronised input went 0 -> 1
//   fall out 1-clk pulse, synchronised input went 1 -> 0
// Pulses appear 3 clk after the pin edge (2 sync stages + edge register).
module audio_rx_sync_edge_det
    import audio_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    localparam int unsigned WARM_W = SYNC_STAGES + 1;

    logic              meta_q, meta_d;
    logic              d0_q, d0_d;
    logic              d1_q, d1_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Edge detection is held off until d0 and d1 both carry real pin samples,
    // so a line already high at reset release is not mistaken for an edge.
    always_comb begin
        meta_d = din;
        d0_d   = meta_q;
        d1_d   = d0_q;
        warm_d = {warm_q[WARM_W-2:0], 1'b1};
        rise_d = warm_q[WARM_W-1] &  d0_q & ~d1_q;
        fall_d = warm_q[WARM_W-1] & ~d0_q &  d1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            d0_q   <= 1'b0;
            d1_q   <= 1'b0;
            warm_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            warm_q <= warm_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/audio_rx.sv
// Serial audio receiver for the WM8731 ADC path (codec is bus master).
// Oversamples bclk, LRC and data in the clk domain, deserialises one left and
// one right word per LRC frame (MSB first, left-aligned) and presents the pair
// with a one-cycle valid strobe.
//   clk        in  system clock, >= 8x sck_bclk
//   rst        in  asynchronous active-high reset
//   sck_bclk   in  codec bit clock (asynchronous)
//   ws_lrc     in  LR clock, 1 = left, 0 = right
//   sdata      in  serial data, changes on bclk falling edge
//   left_data  out last complete left word
//   right_data out last complete right word
//   data_valid out 1-clk pulse, left_data/right_data updated as a pair
module audio_rx
    import audio_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck_bclk,
    input  logic                  ws_lrc,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  data_valid
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic bclk_rise;
    logic lrc_rise;
    logic lrc_fall;
    logic left_start;
    logic right_start;

    // Serial data pipeline: 2 sync stages plus one flop to line up with the
    // registered bclk edge pulse.
    logic sd_meta_q, sd_meta_d;
    logic sd_d0_q,   sd_d0_d;
    logic sd_al_q,   sd_al_d;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [DATA_WIDTH-1:0] left_data_q, left_data_d;
    logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
    logic                  data_valid_q, data_valid_d;
    rx_state_e             state_q, state_d;

    audio_rx_sync_edge_det u_bclk_det (
        .clk  (clk),
        .rst  (rst),
        .din  (sck_bclk),
        .rise (bclk_rise),
        .fall ()
    );

    audio_rx_sync_edge_det u_lrc_det (
        .clk  (clk),
        .rst  (rst),
        .din  (ws_lrc),
        .rise (lrc_rise),
        .fall (lrc_fall)
    );

    // Map LRC edges onto channel starts using the shared polarity constant.
    assign left_start  = (AUDIO_LRC_LEFT == 1'b1) ? lrc_rise : lrc_fall;
    assign right_start = (AUDIO_LRC_LEFT == 1'b1) ? lrc_fall : lrc_rise;

    always_comb begin
        sd_meta_d = sdata;
        sd_d0_d   = sd_meta_q;
        sd_al_d   = sd_d0_q;
    end

    // Deserialiser: an LRC edge restarts the word; a bit sampled in the same
    // cycle lands as bit 0 of the new channel. Bits past DATA_WIDTH are dropped.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (lrc_rise || lrc_fall) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
        if (bclk_rise && (bit_cnt_d < CNT_W'(DATA_WIDTH))) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                if (bit_cnt_d == CNT_W'(DATA_WIDTH - 1 - i)) begin
                    shift_d[i] = sd_al_q;
                end
            end
            bit_cnt_d = bit_cnt_d + CNT_W'(1);
        end
    end

    // Frame FSM. shift_q is read before this cycle's sample, so a bit taken on
    // the channel-change cycle never leaks into the finished word.
    always_comb begin
        state_d      = state_q;
        left_hold_d  = left_hold_q;
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (left_start) begin
                    state_d = ST_LEFT;
                end
            end
            ST_LEFT: begin
                // A second left start (missed right start) just restarts the
                // left word; the deserialiser has already cleared it.
                if (right_start) begin
                    left_hold_d = shift_q;
                    state_d     = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (left_start) begin
                    left_data_d  = left_hold_q;
                    right_data_d = shift_q;
                    data_valid_d = 1'b1;
                    state_d      = ST_LEFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_meta_q    <= 1'b0;
            sd_d0_q      <= 1'b0;
            sd_al_q      <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            left_hold_q  <= '0;
            left_data_q  <= '0;
            right_data_q <= '0;
            data_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            sd_meta_q    <= sd_meta_d;
            sd_d0_q      <= sd_d0_d;
            sd_al_q      <= sd_al_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            left_hold_q  <= left_hold_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            data_valid_q <= data_valid_d;
            state_q      <= state_d;
        end
    end

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_audio_rx.sv
// Scoreboard bench for audio_rx: a 32-bit and a 16-bit instance share the same
// serial stream; expected pairs are queued as frames are sent and a negedge
// monitor pops and compares on every data_valid pulse.
module tb_audio_rx;

    localparam int HALF = 160;  // bclk half period, a multiple of the clk period

    logic        clk = 1'b0;
    logic        rst;
    logic        sck_bclk;
    logic        ws_lrc;
    logic        sdata;
    logic [31:0] l32, r32;
    logic        v32;
    logic [15:0] l16, r16;
    logic        v16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int n_pulse32 = 0;
    int n_pulse16 = 0;
    int n_pushed = 0;

    logic [63:0] q32[$];
    logic [31:0] q16[$];

    always #10 clk = ~clk;

    audio_rx #(.DATA_WIDTH(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .sck_bclk   (sck_bclk),
        .ws_lrc     (ws_lrc),
        .sdata      (sdata),
        .left_data  (l32),
        .right_data (r32),
        .data_valid (v32)
    );

    audio_rx #(.DATA_WIDTH(16)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .sck_bclk   (sck_bclk),
        .ws_lrc     (ws_lrc),
        .sdata      (sdata),
        .left_data  (l16),
        .right_data (r16),
        .data_valid (v16)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge ws_lrc) rise_cyc = cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected pair for both widths; words are left-aligned in 32 bits.
    task automatic push(input logic [31:0] l, input logic [31:0] r);
        q32.push_back({l, r});
        q16.push_back({l[31:16], r[31:16]});
        n_pushed++;
    endtask

    // One channel: LRC and data change with bclk low, sampled on bclk rise.
    task automatic half_word(input logic ws, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sck_bclk = 1'b0;
            ws_lrc   = ws;
            sdata    = w[n-1-i];
            #HALF;
            sck_bclk = 1'b1;
            #HALF;
        end
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
        push(l << (32 - n), r << (32 - n));
        half_word(1'b1, l, n);
        half_word(1'b0, r, n);
    endtask

    // Monitor: every pulse must match the oldest queued pair, 4 clk after LRC rise.
    always @(negedge clk) begin
        logic [63:0] e32;
        logic [31:0] e16;
        if (v32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse32: got unexpected pulse, expected none");
            end else begin
                e32 = q32.pop_front();
                n_pulse32++;
                check("left32", l32, e32[63:32]);
                check("right32", r32, e32[31:0]);
                check("latency32", 32'(cyc - rise_cyc), 32'd4);
            end
        end
        if (v16 === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse16: got unexpected pulse, expected none");
            end else begin
                e16 = q16.pop_front();
                n_pulse16++;
                check("left16", {16'd0, l16}, {16'd0, e16[31:16]});
                check("right16", {16'd0, r16}, {16'd0, e16[15:0]});
            end
        end
    end

    initial begin
        rst      = 1'b1;
        sck_bclk = 1'b0;
        ws_lrc   = 1'b0;
        sdata    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_left", l32, 32'd0);
        check("rst_right", r32, 32'd0);
        check("rst_valid", {31'd0, v32}, 32'd0);

        // Align all pin changes to 5 time units after a clk rising edge.
        @(posedge clk);
        #5;

        // Startup: reset released in the middle of a right word.
        half_word(1'b0, 32'hFFFF_FFFF, 16);
        rst = 1'b0;
        half_word(1'b0, 32'hFFFF_FFFF, 16);

        frame(32'hA5A5_1234, 32'h0F0F_8001, 32);
        frame(32'h1122_3344, 32'h5566_7788, 32);
        frame(32'h00AB_CDEF, 32'h0012_3456, 24);
        frame(32'h1234_5678, 32'h9ABC_DEF0, 32);

        // LRC held high for two frames: only the first 32 left bits are kept.
        push(32'hCAFE_F00D, 32'h0BAD_C0DE);
        half_word(1'b1, 32'hCAFE_F00D, 32);
        for (int k = 0; k < 3; k++) half_word(1'b1, 32'h0000_0000, 32);
        half_word(1'b0, 32'h0BAD_C0DE, 32);

        frame(32'h1357_9BDF, 32'h2468_ACE0, 32);

        // Reset in the middle of a left word.
        half_word(1'b1, 32'h7777_7777, 12);
        rst = 1'b1;
        #1;
        check("midrst_left", l32, 32'd0);
        check("midrst_right", r32, 32'd0);
        check("midrst_valid", {31'd0, v32}, 32'd0);
        check("midrst_left16", {16'd0, l16}, 32'd0);
        #(2 * HALF - 1);
        rst = 1'b0;
        half_word(1'b1, 32'h7777_7777, 20);
        half_word(1'b0, 32'h5555_5555, 32);

        frame(32'hFEDC_BA98, 32'h0123_4567, 32);
        half_word(1'b1, 32'h0000_0000, 32);

        repeat (20) @(posedge clk);
        #1;
        check("queue32_empty", 32'(q32.size()), 32'd0);
        check("queue16_empty", 32'(q16.size()), 32'd0);
        check("pulses32", 32'(n_pulse32), 32'(n_pushed));
        check("pulses16", 32'(n_pulse16), 32'(n_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
